// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding and the default round
// count, used by both the round controller and the AES datapath.
package aes_pkg;

  // AES-128 performs ten rounds after the initial AddRoundKey.
  localparam int AES_NR_DEFAULT = 10;

  // Round controller FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } aes_state_t;

endpackage

// File: rtl/aes_round_cnt.sv
// Round counter for the AES controller: synchronous clear, increment, and a
// terminal-count flag that goes high when the count equals TC_VAL.
module aes_round_cnt #(
  parameter int             RW     = 4,
  parameter logic [RW-1:0]  TC_VAL = '0
) (
  input  logic          pi_clk,
  input  logic          pi_rst_n,
  input  logic          pi_clr,
  input  logic          pi_inc,
  output logic [RW-1:0] po_cnt,
  output logic          po_tc
);

  // Count register; clear wins over increment so a new operation always starts at zero.
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      po_cnt <= '0;
    end else if (pi_clr) begin
      po_cnt <= '0;
    end else if (pi_inc) begin
      po_cnt <= po_cnt + RW'(1);
    end
  end

  assign po_tc = (po_cnt == TC_VAL);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: on a rising edge of pi_start it walks the datapath
// through LOAD (initial AddRoundKey), NR-1 full rounds, one final round without
// MixColumns, and a one-cycle DONE pulse. Every output comes from a register
// or is decoded from the current state.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_DEFAULT,
  parameter int RW = 4
) (
  input  logic          pi_clk,
  input  logic          pi_rst_n,
  input  logic          pi_start,
  input  logic          pi_mode,
  input  logic          pi_abort,
  input  logic          pi_dp_ready,
  output logic          po_busy,
  output logic          po_load,
  output logic          po_round_en,
  output logic          po_mixcol,
  output logic [RW-1:0] po_round,
  output logic          po_mode,
  output logic          po_done
);

  // The last "full" round is NR-1; accepting it moves us to the final round.
  localparam logic [RW-1:0] LAST_FULL_ROUND = RW'(NR - 1);

  aes_state_t state;
  aes_state_t next_state;
  logic       start_dly;
  logic       start_edge;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       cnt_tc;
  logic       mode_q;

  assign start_edge = pi_start & ~start_dly;

  aes_round_cnt #(
    .RW     (RW),
    .TC_VAL (LAST_FULL_ROUND)
  ) u_round_cnt (
    .pi_clk   (pi_clk),
    .pi_rst_n (pi_rst_n),
    .pi_clr   (cnt_clr),
    .pi_inc   (cnt_inc),
    .po_cnt   (po_round),
    .po_tc    (cnt_tc)
  );

  // Delayed copy of pi_start; resets high so a start held through reset is not an edge.
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      start_dly <= 1'b1;
    end else begin
      start_dly <= pi_start;
    end
  end

  // Mode is captured only when an operation is accepted and held until the next one.
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      mode_q <= 1'b0;
    end else if ((state == ST_IDLE) && start_edge) begin
      mode_q <= pi_mode;
    end
  end

  // State register.
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and counter control; abort beats dp_ready in every busy state.
  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          next_state = ST_LOAD;
          cnt_clr    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (pi_abort) begin
          next_state = ST_IDLE;
          cnt_clr    = 1'b1;
        end else begin
          cnt_inc    = 1'b1;
          next_state = cnt_tc ? ST_FINAL : ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (pi_abort) begin
          next_state = ST_IDLE;
          cnt_clr    = 1'b1;
        end else if (pi_dp_ready) begin
          cnt_inc    = 1'b1;
          next_state = cnt_tc ? ST_FINAL : ST_ROUND;
        end
      end
      ST_FINAL: begin
        if (pi_abort) begin
          next_state = ST_IDLE;
          cnt_clr    = 1'b1;
        end else if (pi_dp_ready) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode from the current state only.
  always_comb begin
    po_busy     = 1'b0;
    po_load     = 1'b0;
    po_round_en = 1'b0;
    po_mixcol   = 1'b0;
    po_done     = 1'b0;
    case (state)
      ST_LOAD: begin
        po_busy = 1'b1;
        po_load = 1'b1;
      end
      ST_ROUND: begin
        po_busy     = 1'b1;
        po_round_en = 1'b1;
        po_mixcol   = 1'b1;
      end
      ST_FINAL: begin
        po_busy     = 1'b1;
        po_round_en = 1'b1;
      end
      ST_DONE: begin
        po_done = 1'b1;
      end
      default: begin
        po_busy = 1'b0;
      end
    endcase
  end

  assign po_mode = mode_q;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10, meaning: number of AES rounds after the initial key addition (legal range 1..15).
REQ-002 Parameter RW, default 4, meaning: width of the round index output; SHALL satisfy 2**RW > NR.
REQ-003 pi_clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 pi_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pi_start  input  1  level request; only a rising edge starts an operation.
REQ-006 pi_mode  input  1  0 = encrypt, 1 = decrypt; sampled on the start edge.
REQ-007 pi_abort  input  1  synchronous cancel of the current operation.
REQ-008 pi_dp_ready  input  1  datapath has accepted the current round.
REQ-009 po_busy  output  1  operation in progress.
REQ-010 po_load  output  1  datapath loads state and performs the round-0 AddRoundKey.
REQ-011 po_round_en  output  1  datapath executes the round given by po_round.
REQ-012 po_mixcol  output  1  MixColumns enable for the current round.
REQ-013 po_round  output  RW  current round index.
REQ-014 po_mode  output  1  latched mode for the datapath and key schedule.
REQ-015 po_done  output  1  single-cycle completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, ROUND, FINAL and DONE.
REQ-017 Start edge detection: start_edge = pi_start & ~start_dly, where start_dly is registered from pi_start every cycle.
REQ-018 IDLE: on start_edge, the FSM SHALL go to LOAD, latch pi_mode into po_mode and set po_round = 0; otherwise it stays in IDLE.
REQ-019 LOAD lasts exactly one cycle with po_load = 1, then the FSM goes to ROUND with po_round = 1.
REQ-020 ROUND: po_round_en = 1 and po_mixcol = 1. When pi_dp_ready = 1, po_round increments. After round NR-1 is accepted, the FSM goes to FINAL with po_round = NR.
REQ-021 ROUND, NR = 1: the FSM goes from LOAD directly to FINAL with po_round = 1.
REQ-022 While pi_dp_ready = 0, the FSM holds its state and all outputs stay stable; there is no timeout.
REQ-023 FINAL: po_round_en = 1 and po_mixcol = 0. When pi_dp_ready = 1, the FSM goes to DONE.
REQ-024 DONE lasts exactly one cycle with po_done = 1 and po_busy = 0, then the FSM goes to IDLE; po_round holds NR until the next start.
REQ-025 po_busy = 1 exactly in LOAD, ROUND and FINAL; po_load, po_round_en, po_mixcol and po_done are 0 in every state not listed above.
REQ-026 A start edge seen in any state other than IDLE SHALL be ignored and not queued.
REQ-027 pi_start held high SHALL NOT retrigger an operation after DONE; a new low-to-high transition is required.
REQ-028 pi_abort = 1 in any busy state forces IDLE on the next edge with po_round = 0 and no po_done. Abort has priority over pi_dp_ready. Abort in IDLE or DONE has no effect.
REQ-029 Latency: with pi_dp_ready held at 1, po_done is high in cycle NR+2 counted from the edge that samples start_edge (cycle 12 for NR = 10).
REQ-030 po_mode SHALL NOT change between the start edge and DONE, regardless of pi_mode.
REQ-031 All outputs SHALL be registered or decoded only from state; there is no combinational path from input to output.

Reset
REQ-032 While pi_rst_n = 0: state = IDLE, po_round = 0, po_mode = 0, and all single-bit outputs = 0.
REQ-033 start_dly SHALL reset to 1, so a pi_start held high through reset does not start an operation.
REQ-034 Reset asserted mid-operation aborts immediately without po_done; a start edge is accepted on the first edge after release.

Structure
REQ-035 Package aes_pkg holds the FSM state typedef and the NR default constant, shared with the AES datapath.
REQ-036 One sub-module, aes_round_cnt, SHALL implement the round counter: clear, increment and terminal-count flag, RW wide, with asynchronous active-low reset.

Verification
REQ-037 Reset, then a pi_start 0->1 pulse with pi_dp_ready = 1 -> po_load in cycle 1, po_round 1..9 with po_mixcol = 1, round 10 with po_mixcol = 0, po_done in cycle 12.
REQ-038 pi_dp_ready = 0 for 3 cycles at round 5 -> po_round stays at 5 for 4 cycles; po_done arrives 3 cycles late.
REQ-039 Start edge at round 4, then pi_start held high after DONE -> exactly one po_done and no restart.
REQ-040 pi_abort together with pi_dp_ready = 1 at round 7 -> IDLE next cycle, po_round = 0, no po_done; a later edge runs a full operation.
REQ-041 pi_start high while pi_rst_n is released -> no operation starts; pi_mode toggled mid-operation -> po_mode stays constant.
REQ-042 Parameter sweep NR = 1 and NR = 14 -> po_done in cycles 3 and 16 respectively.
